// File: rtl/dwt_pkg.sv
// Shared constants and types for the DWT band serializer: band codes,
// block geometry, default widths and the coefficient-phase type.
package dwt_pkg;

    localparam logic BAND_LO = 1'b0;
    localparam logic BAND_HI = 1'b1;

    localparam int N_PAR = 6;
    localparam int N_DEC = 3;

    localparam int Y_W_DEF   = 25;
    localparam int OUT_W_DEF = 16;

    localparam int PH_W = $clog2(N_PAR);
    typedef logic [PH_W-1:0] phase_t;

    localparam phase_t PH_LAST = phase_t'(N_PAR - 1);

    // Words alternate low/high within a block, so the band is the phase LSB.
    function automatic logic band_of(input phase_t ph);
        return ph[0] ? BAND_HI : BAND_LO;
    endfunction

endpackage

// File: rtl/dwt_quant.sv
// Combinational round-half-up, arithmetic right shift and saturation of one
// signed filter output down to the narrower output coefficient width.
module dwt_quant #(
    parameter int Y_W   = 25,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic signed [Y_W-1:0]   i_y,
    output logic signed [OUT_W-1:0] o_q
);

    localparam int EW = Y_W + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] RND     = (SHIFT > 0) ? (EW'(1) << RS) : '0;
    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [EW-1:0] w_rnd;
    logic signed [EW-1:0] w_shf;

    // One guard bit keeps the rounding add from wrapping at the positive limit.
    assign w_rnd = $signed({i_y[Y_W-1], i_y}) + RND;
    assign w_shf = w_rnd >>> SHIFT;

    // NOTE: o_q gets a default before the branches so no path leaves it unassigned (no latch).
    always_comb begin
        o_q = w_shf[OUT_W-1:0];
        if (w_shf > SAT_MAX) begin
            o_q = SAT_MAX[OUT_W-1:0];
        end else if (w_shf < SAT_MIN) begin
            o_q = SAT_MIN[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dwt_band_serializer.sv
// Decimates a DWT beat to its even phases, quantises the six kept words and
// streams buffered blocks one coefficient per cycle with low/high interleave.
module dwt_band_serializer
    import dwt_pkg::*;
#(
    parameter int Y_W   = Y_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic signed [Y_W-1:0]          lo_y0,
    input  logic signed [Y_W-1:0]          lo_y1,
    input  logic signed [Y_W-1:0]          lo_y2,
    input  logic signed [Y_W-1:0]          lo_y3,
    input  logic signed [Y_W-1:0]          lo_y4,
    input  logic signed [Y_W-1:0]          lo_y5,
    input  logic signed [Y_W-1:0]          hi_y0,
    input  logic signed [Y_W-1:0]          hi_y1,
    input  logic signed [Y_W-1:0]          hi_y2,
    input  logic signed [Y_W-1:0]          hi_y3,
    input  logic signed [Y_W-1:0]          hi_y4,
    input  logic signed [Y_W-1:0]          hi_y5,
    input  logic                           in_valid,
    output logic signed [OUT_W-1:0]        out_data,
    output logic                           out_band,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow,
    input  logic                           ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic signed [Y_W-1:0]   w_lo_even [N_DEC];
    logic signed [Y_W-1:0]   w_hi_even [N_DEC];
    logic signed [Y_W-1:0]   w_raw     [N_PAR];
    logic signed [OUT_W-1:0] w_q       [N_PAR];
    logic                    w_unused_odd;

    logic signed [OUT_W-1:0] r_mem [DEPTH][N_PAR];
    logic [AW-1:0]           r_wptr;
    logic [AW-1:0]           r_rptr;
    logic [LW-1:0]           r_level;
    phase_t                  r_phase;
    logic                    r_ovf;

    logic w_xfer;
    logic w_pop;
    logic w_accept;
    logic w_drop;

    assign w_lo_even[0] = lo_y0;
    assign w_lo_even[1] = lo_y2;
    assign w_lo_even[2] = lo_y4;
    assign w_hi_even[0] = hi_y0;
    assign w_hi_even[1] = hi_y2;
    assign w_hi_even[2] = hi_y4;

    // Odd phases are discarded by the 2:1 decimation.
    assign w_unused_odd = ^{lo_y1, lo_y3, lo_y5, hi_y1, hi_y3, hi_y5};

    for (genvar i = 0; i < N_DEC; i++) begin : g_order
        assign w_raw[2*i]   = w_lo_even[i];
        assign w_raw[2*i+1] = w_hi_even[i];
    end

    for (genvar i = 0; i < N_PAR; i++) begin : g_quant
        dwt_quant #(
            .Y_W   (Y_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_quant (
            .i_y (w_raw[i]),
            .o_q (w_q[i])
        );
    end

    assign out_valid = (r_level != '0);
    assign w_xfer    = out_valid && out_ready;
    assign w_pop     = w_xfer && (r_phase == PH_LAST);
    // A full buffer still takes a block when its head block leaves this cycle.
    assign w_accept  = in_valid && ((r_level < LW'(DEPTH)) || w_pop);
    assign w_drop    = in_valid && !w_accept;

    assign out_data = out_valid ? r_mem[r_rptr][r_phase] : '0;
    assign out_band = out_valid ? band_of(r_phase) : BAND_LO;
    assign level    = r_level;
    assign overflow = r_ovf;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_phase <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_xfer) begin
                r_phase <= w_pop ? phase_t'(0) : r_phase + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; out_valid gates it, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 0; j < N_PAR; j++) begin
                r_mem[r_wptr][j] <= w_q[j];
            end
        end
    end

endmodule

// File: tb/tb_dwt_band_serializer.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a queue-of-blocks reference model of the serializer.
module tb_dwt_band_serializer;

    localparam int Y_W   = 25;
    localparam int OUT_W = 16;
    localparam int SHIFT = 8;
    localparam int DEPTH = 4;
    localparam int LW    = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic signed [Y_W-1:0] lo [6];
    logic signed [Y_W-1:0] hi [6];
    logic in_valid  = 1'b0;
    logic out_ready = 1'b0;
    logic ovf_clr   = 1'b0;

    logic signed [OUT_W-1:0] out_data;
    logic                    out_band;
    logic                    out_valid;
    logic [LW-1:0]           level;
    logic                    overflow;

    dwt_band_serializer #(
        .Y_W(Y_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .lo_y0(lo[0]), .lo_y1(lo[1]), .lo_y2(lo[2]),
        .lo_y3(lo[3]), .lo_y4(lo[4]), .lo_y5(lo[5]),
        .hi_y0(hi[0]), .hi_y1(hi[1]), .hi_y2(hi[2]),
        .hi_y3(hi[3]), .hi_y4(hi[4]), .hi_y5(hi[5]),
        .in_valid(in_valid),
        .out_data(out_data), .out_band(out_band), .out_valid(out_valid),
        .out_ready(out_ready),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef int blk_t [6];
    blk_t mq [$];
    int   mph  = 0;
    bit   movf = 1'b0;

    function automatic int quant(input logic signed [Y_W-1:0] y);
        longint r;
        longint rnd;
        longint lim;
        rnd = 0;
        if (SHIFT > 0) rnd = longint'(1) << (SHIFT - 1);
        r   = (longint'(y) + rnd) >>> SHIFT;
        lim = longint'(1) << (OUT_W - 1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim)    r = -lim;
        return int'(r);
    endfunction

    function automatic logic signed [OUT_W-1:0] exp_data();
        if (mq.size() == 0) return '0;
        return OUT_W'(mq[0][mph]);
    endfunction

    function automatic logic exp_band();
        return (mq.size() != 0) && ((mph % 2) == 1);
    endfunction

    function automatic logic [LW-1:0] exp_level();
        return LW'(mq.size());
    endfunction

    function automatic logic signed [Y_W-1:0] rand_y();
        int m;
        m = int'($urandom_range(0, 3));
        case (m)
            0:       return Y_W'($urandom);
            1:       return Y_W'(int'($urandom_range(0, 4095)) - 2048);
            2:       return Y_W'((int'($urandom_range(0, 200)) - 100) * 256 + 128);
            default: return Y_W'($urandom_range(0, 1) ? 32'sh00FF_FF00 : -32'sh00FF_FF00);
        endcase
    endfunction

    task automatic rand_block();
        for (int i = 0; i < 6; i++) begin
            lo[i] = rand_y();
            hi[i] = rand_y();
        end
    endtask

    // Drives one cycle (called at a negedge), advances the model, returns at the next negedge.
    task automatic step(input bit v, input bit rdy, input bit clr);
        blk_t b;
        bit   xfer;
        bit   pop;
        bit   acc;
        in_valid  = v;
        out_ready = rdy;
        ovf_clr   = clr;
        xfer = (mq.size() != 0) && rdy;
        pop  = xfer && (mph == 5);
        acc  = v && ((mq.size() < DEPTH) || pop);
        for (int k = 0; k < 3; k++) begin
            b[2*k]   = quant(lo[2*k]);
            b[2*k+1] = quant(hi[2*k]);
        end
        if (xfer) mph++;
        if (pop) begin
            mq.delete(0);
            mph = 0;
        end
        if (acc) mq.push_back(b);
        if (v && !acc) movf = 1'b1;
        else if (clr)  movf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            lo[i] = '0;
            hi[i] = '0;
        end
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL reset_data: got %0d want 0", out_data); end
        n_checks++; if (out_band !== 1'b0)  begin n_fail++; $display("FAIL reset_band: got %0b want 0", out_band); end
        n_checks++; if (level !== '0)       begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        n_checks++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %0b want 0", out_valid); end
    endtask

    task automatic directed_block(input string name, input int want [6]);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid[%0d]: got %0b want 1", name, k, out_valid); end
            n_checks++; if (out_data !== OUT_W'(want[k])) begin n_fail++; $display("FAIL %s_data[%0d]: got %0d want %0d", name, k, out_data, want[k]); end
            n_checks++; if (out_band !== k[0]) begin n_fail++; $display("FAIL %s_band[%0d]: got %0b want %0b", name, k, out_band, k[0]); end
            step(1'b0, 1'b1, 1'b0);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_end: got %0b want 0", name, out_valid); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL %s_level_end: got %0d want 0", name, level); end
    endtask

    task automatic test_single_block();
        int want [6];
        want = '{1, -1, 2, -2, 3, -3};
        for (int i = 0; i < 6; i++) begin
            lo[i] = Y_W'(25'h0FFFFFF);
            hi[i] = Y_W'(25'h0FFFFFF);
        end
        lo[0] = 256;  lo[2] = 512;  lo[4] = 768;
        hi[0] = -256; hi[2] = -512; hi[4] = -768;
        directed_block("single", want);
    endtask

    task automatic test_round_sat();
        int want [6];
        want = '{4, 32767, -4, -32768, 1, 0};
        for (int i = 0; i < 6; i++) begin
            lo[i] = '0;
            hi[i] = '0;
        end
        lo[0] = 1000;      lo[2] = -1000;      lo[4] = 128;
        hi[0] = 25'sd8388608; hi[2] = -25'sd8388608; hi[4] = 0;
        directed_block("roundsat", want);
    endtask

    task automatic test_backpressure();
        int exp_words [$];
        int rx [$];
        for (int b = 0; b < 2; b++) begin
            rand_block();
            for (int k = 0; k < 3; k++) begin
                exp_words.push_back(quant(lo[2*k]));
                exp_words.push_back(quant(hi[2*k]));
            end
            step(1'b1, 1'b0, 1'b0);
        end
        for (int c = 0; c < 48 && mq.size() != 0; c++) begin
            bit rdy;
            rdy = ((c % 4) == 0) || ((c % 4) == 3);
            n_checks++; if (out_data !== exp_data() || out_band !== exp_band()) begin
                n_fail++; $display("FAIL bp_word[%0d]: got %0d/%0b want %0d/%0b", c, out_data, out_band, exp_data(), exp_band());
            end
            if (rdy && out_valid) rx.push_back(int'(out_data));
            step(1'b0, rdy, 1'b0);
        end
        n_checks++; if (rx.size() != 12) begin n_fail++; $display("FAIL bp_count: got %0d want 12", rx.size()); end
        for (int i = 0; i < 12 && i < rx.size(); i++) begin
            n_checks++; if (rx[i] != exp_words[i]) begin n_fail++; $display("FAIL bp_rx[%0d]: got %0d want %0d", i, rx[i], exp_words[i]); end
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow_and_full_pop();
        for (int b = 0; b < 5; b++) begin
            rand_block();
            step(1'b1, 1'b0, 1'b0);
        end
        n_checks++; if (level !== 3'd4)    begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b want 1", overflow); end
        rand_block();
        step(1'b1, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %0b want 1", overflow); end
        step(1'b0, 1'b0, 1'b1);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL fp_head[%0d]: got %0d want %0d", k, out_data, exp_data()); end
            step(1'b0, 1'b1, 1'b0);
        end
        n_checks++; if (out_band !== 1'b1 || level !== 3'd4) begin
            n_fail++; $display("FAIL fp_phase5: got band %0b level %0d want band 1 level 4", out_band, level);
        end
        rand_block();
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (level !== 3'd4)    begin n_fail++; $display("FAIL fp_level: got %0d want 4", level); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fp_overflow: got %0b want 0", overflow); end
        for (int c = 0; c < 40 && mq.size() != 0; c++) begin
            n_checks++; if (out_data !== exp_data() || out_band !== exp_band()) begin
                n_fail++; $display("FAIL fp_drain[%0d]: got %0d/%0b want %0d/%0b", c, out_data, out_band, exp_data(), exp_band());
            end
            step(1'b0, 1'b1, 1'b0);
        end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fp_empty: got %0b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        rand_block();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rm_word2: got %0d want %0d", out_data, exp_data()); end
        #1 rstn = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %0b want 0", out_valid); end
        n_checks++; if (level !== '0)       begin n_fail++; $display("FAIL rm_level: got %0d want 0", level); end
        n_checks++; if (out_data !== '0)    begin n_fail++; $display("FAIL rm_data: got %0d want 0", out_data); end
        mq.delete();
        mph  = 0;
        movf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_after_release: got %0b want 0", out_valid); end
        rand_block();
        step(1'b1, 1'b1, 1'b0);
        n_checks++; if (out_data !== OUT_W'(quant(lo[0])) || out_band !== 1'b0) begin
            n_fail++; $display("FAIL rm_new_l0: got %0d/%0b want %0d/0", out_data, out_band, quant(lo[0]));
        end
        for (int c = 0; c < 12 && mq.size() != 0; c++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int pv;
            pv = (c < 300) ? 35 : 8;
            n_checks++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, out_valid, mq.size() != 0); end
            n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data[%0d]: got %0d want %0d", c, out_data, exp_data()); end
            n_checks++; if (out_band !== exp_band()) begin n_fail++; $display("FAIL rnd_band[%0d]: got %0b want %0b", c, out_band, exp_band()); end
            n_checks++; if (level !== exp_level()) begin n_fail++; $display("FAIL rnd_level[%0d]: got %0d want %0d", c, level, exp_level()); end
            n_checks++; if (overflow !== movf) begin n_fail++; $display("FAIL rnd_overflow[%0d]: got %0b want %0b", c, overflow, movf); end
            rand_block();
            step($urandom_range(0, 99) < pv, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_round_sat();
        test_backpressure();
        test_overflow_and_full_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dwt_band_serializer.md
# dwt_band_serializer

Output stage placed directly after the one-level DWT filter pair. Each input beat carries six parallel low-pass (approximation) and six high-pass (detail) filter outputs. The block does three things to each beat:
- decimates by 2, keeping the even phases;
- rounds and saturates every kept coefficient to a narrower output width;
- buffers the resulting blocks and streams them one coefficient per cycle over a valid/ready interface, with approximation and detail samples interleaved.

The upstream filters have no backpressure, so the block drops whole blocks when its buffer is full and reports this on a sticky flag.

## Interface
Parameters:
- Y_W, 25, width of each signed filter output
- OUT_W, 16, width of signed output coefficient
- SHIFT, 8, right-shift applied before saturation (0 allowed)
- DEPTH, 4, block buffer depth in blocks (power of two, ≥2)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- lo_y0..lo_y5  in  Y_W each  signed low-pass outputs for samples 6k..6k+5
- hi_y0..hi_y5  in  Y_W each  signed high-pass outputs for samples 6k..6k+5
- in_valid  in  1  all twelve inputs valid this cycle (no ready)
- out_data  out  OUT_W  signed coefficient
- out_band  out  1  0 = approximation (low), 1 = detail (high)
- out_valid  out  1  out_data/out_band valid
- out_ready  in  1  consumer accepts this cycle
- level  out  clog2(DEPTH+1)  blocks held in the buffer
- overflow  out  1  sticky; set when a block is dropped
- ovf_clr  in  1  synchronous clear of overflow

## Operation
- Decimation: only phases 0, 2 and 4 (lo_y0/2/4, hi_y0/2/4) are used; odd phases are ignored.
- Quantise each kept value: q = (y + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT (arithmetic), computed at Y_W+1 bits. Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Block = six quantised words, emitted in the order L0, H0, L2, H2, L4, H4. out_band follows 0,1,0,1,0,1.
- Write: on an in_valid cycle, the block is accepted if level < DEPTH, or if the final word of the head block pops in the same cycle. Otherwise the block is dropped and overflow is set.
- Read: the head block is presented through a phase counter 0..5.
  - A transfer occurs when out_valid && out_ready.
  - A transfer advances the phase.
  - A transfer at phase 5 pops the block and resets the phase to 0.
- out_valid = (level != 0).
- ovf_clr clears overflow. If a drop occurs in the same cycle as ovf_clr, overflow stays set (set wins).
- level changes +1 on accept-only, −1 on pop-only, and is unchanged on accept+pop.

## Timing
- Reset values: out_valid 0, out_data 0, out_band 0, level 0, overflow 0, phase 0, buffer pointers 0.
- Latency: in_valid at edge t into an empty buffer gives out_valid=1 with word L0 from edge t+1.
- When out_ready is held high, the six words occupy six consecutive cycles.
- While out_valid && !out_ready: out_data, out_band and the phase are held stable.
- Pointers wrap modulo DEPTH.
- Reset asserted mid-block discards all buffered and partial blocks. Outputs return to their reset values asynchronously.

## Structure
- Shared package dwt_pkg holds:
  - band constants BAND_LO=0, BAND_HI=1;
  - N_PAR=6 and N_DEC=3;
  - default Y_W/OUT_W widths.
- Sub-module dwt_quant does the combinational round+saturate, parameterised by Y_W, OUT_W and SHIFT. It is instantiated six times.
- Buffer storage: DEPTH × 6 × OUT_W register array plus read/write pointers. No vendor RAM.

## Test plan
- Single block, out_ready=1, SHIFT=8.
  - Stimulus: lo_y0/2/4 = 256, 512, 768; hi_y0/2/4 = −256, −512, −768; odd phases = 0x0FFFFFF.
  - Expected: out_data sequence 1,−1,2,−2,3,−3 with band 0,1,0,1,0,1 on cycles t+1..t+6; out_valid then drops.
- Rounding and saturation:
  - lo_y0 = 1000 → 4; lo_y2 = −1000 → −4; lo_y4 = 128 → 1;
  - hi_y0 = 2^23 → 32767; hi_y2 = −2^23 → −32768.
- Backpressure: out_ready toggled 1,0,0,1,... → no word lost or duplicated, and data is stable during stalls.
- Overflow: out_ready=0 and five in_valid pulses with DEPTH=4 → level 4, overflow=1, fifth block absent. Then ovf_clr → overflow 0.
- Full with simultaneous pop: level=4, head at phase 5, out_ready=1 and in_valid in the same cycle → block accepted, level stays 4, overflow stays 0.
- Reset mid-stream: rstn low during the 3rd word → out_valid 0 and level 0 immediately. After release, a new block starts at L0.
